// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int LINES      = 8;
    localparam int LINE_BYTES = 4;
    localparam int TAG_W      = 3;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WB_ACC   = 3'd1,
        WB_GAP   = 3'd2,
        FILL_ACC = 3'd3,
        FILL_GAP = 3'd4,
        UPDATE   = 3'd5
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:IDX_W+OFF_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+OFF_W-1:OFF_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache: one combinational line
// read port, one byte-write port and one line-metadata update port.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic [IDX_W-1:0]                  i_rd_idx,
    output logic [TAG_W-1:0]                  o_rd_tag,
    output logic                              o_rd_valid,
    output logic                              o_rd_dirty,
    output logic [LINE_BYTES-1:0][DATA_W-1:0] o_rd_line,
    input  logic                              i_wr_en,
    input  logic [IDX_W-1:0]                  i_wr_idx,
    input  logic [OFF_W-1:0]                  i_wr_off,
    input  logic [DATA_W-1:0]                 i_wr_data,
    input  logic                              i_wr_set_dirty,
    input  logic                              i_upd_en,
    input  logic [IDX_W-1:0]                  i_upd_idx,
    input  logic [TAG_W-1:0]                  i_upd_tag
);

    logic [LINES-1:0]                  r_valid;
    logic [LINES-1:0]                  r_dirty;
    logic [TAG_W-1:0]                  r_tag  [LINES];
    logic [LINE_BYTES-1:0][DATA_W-1:0] r_data [LINES];

    // Valid/dirty metadata; the only storage cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_upd_en) begin
            r_valid[i_upd_idx] <= 1'b1;
            r_dirty[i_upd_idx] <= 1'b0;
        end else if (i_wr_en && i_wr_set_dirty) begin
            r_dirty[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clock) begin
        if (i_upd_en) begin
            r_tag[i_upd_idx] <= i_upd_tag;
        end
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_off] <= i_wr_data;
        end
    end

    // Combinational line read.
    always_comb begin
        o_rd_tag   = r_tag[i_rd_idx];
        o_rd_valid = r_valid[i_rd_idx];
        o_rd_dirty = r_dirty[i_rd_idx];
        o_rd_line  = r_data[i_rd_idx];
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU and a
// byte-wide data memory; misses write back a dirty line then fill byte by byte.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    state_t            r_state, w_next_state;
    logic [OFF_W-1:0]  r_cnt, w_next_cnt;
    logic              r_held, w_next_held;
    logic [TAG_W-1:0]  r_miss_tag, w_next_miss_tag;
    logic [IDX_W-1:0]  r_miss_idx, w_next_miss_idx;

    logic                              w_req;
    logic                              w_idle;
    logic                              w_hit;
    logic [IDX_W-1:0]                  w_rd_idx;
    logic [TAG_W-1:0]                  w_rd_tag;
    logic                              w_rd_valid;
    logic                              w_rd_dirty;
    logic [LINE_BYTES-1:0][DATA_W-1:0] w_rd_line;
    logic                              w_wr_en;
    logic [OFF_W-1:0]                  w_wr_off;
    logic [DATA_W-1:0]                 w_wr_data;
    logic                              w_wr_set_dirty;
    logic                              w_upd_en;

    // Read and write together count as no request.
    assign w_req    = read ^ write;
    assign w_idle   = (r_state == IDLE);
    // While a miss is in flight the array is addressed by the latched miss index.
    assign w_rd_idx = w_idle ? addr_idx(address) : r_miss_idx;
    assign w_hit    = w_rd_valid && (w_rd_tag == addr_tag(address));

    dcache_array u_array (
        .clock          (clock),
        .reset          (reset),
        .i_rd_idx       (w_rd_idx),
        .o_rd_tag       (w_rd_tag),
        .o_rd_valid     (w_rd_valid),
        .o_rd_dirty     (w_rd_dirty),
        .o_rd_line      (w_rd_line),
        .i_wr_en        (w_wr_en),
        .i_wr_idx       (w_rd_idx),
        .i_wr_off       (w_wr_off),
        .i_wr_data      (w_wr_data),
        .i_wr_set_dirty (w_wr_set_dirty),
        .i_upd_en       (w_upd_en),
        .i_upd_idx      (r_miss_idx),
        .i_upd_tag      (r_miss_tag)
    );

    // CPU-side handshake: stall and hit data are combinational, forced low in reset.
    always_comb begin
        busywait = reset && w_req && !(w_idle && w_hit);
        if (reset && read && !write && w_idle && w_hit) begin
            readdata = w_rd_line[addr_off(address)];
        end else begin
            readdata = {DATA_W{1'b0}};
        end
    end

    // State, byte counter and latched miss address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_held     <= 1'b0;
            r_miss_tag <= 3'd0;
            r_miss_idx <= 3'd0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_held     <= w_next_held;
            r_miss_tag <= w_next_miss_tag;
            r_miss_idx <= w_next_miss_idx;
        end
    end

    // Next-state, array write controls and memory requests (from registers only).
    always_comb begin
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        w_next_held     = r_held;
        w_next_miss_tag = r_miss_tag;
        w_next_miss_idx = r_miss_idx;
        w_wr_en         = 1'b0;
        w_wr_off        = 2'd0;
        w_wr_data       = 8'd0;
        w_wr_set_dirty  = 1'b0;
        w_upd_en        = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 8'd0;
        mem_writedata   = 8'd0;
        case (r_state)
            IDLE: begin
                w_next_cnt  = 2'd0;
                w_next_held = 1'b0;
                if (w_req && w_hit) begin
                    if (write) begin
                        w_wr_en        = 1'b1;
                        w_wr_off       = addr_off(address);
                        w_wr_data      = writedata;
                        w_wr_set_dirty = 1'b1;
                    end else begin
                        w_wr_en = 1'b0;
                    end
                end else if (w_req) begin
                    w_next_miss_tag = addr_tag(address);
                    w_next_miss_idx = addr_idx(address);
                    w_next_state    = w_rd_dirty ? WB_ACC : FILL_ACC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WB_ACC: begin
                mem_write     = 1'b1;
                mem_address   = {w_rd_tag, r_miss_idx, r_cnt};
                mem_writedata = w_rd_line[r_cnt];
                w_next_held   = 1'b1;
                // Completion needs one full cycle of request before memory ready counts.
                if (r_held && !mem_busywait) begin
                    w_next_state = WB_GAP;
                    w_next_held  = 1'b0;
                end else begin
                    w_next_state = WB_ACC;
                end
            end
            WB_GAP: begin
                w_next_cnt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_next_state = FILL_ACC;
                end else begin
                    w_next_state = WB_ACC;
                end
            end
            FILL_ACC: begin
                mem_read    = 1'b1;
                mem_address = {r_miss_tag, r_miss_idx, r_cnt};
                w_next_held = 1'b1;
                if (r_held && !mem_busywait) begin
                    w_wr_en      = 1'b1;
                    w_wr_off     = r_cnt;
                    w_wr_data    = mem_readdata;
                    w_next_state = FILL_GAP;
                    w_next_held  = 1'b0;
                end else begin
                    w_next_state = FILL_ACC;
                end
            end
            FILL_GAP: begin
                w_next_cnt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_next_state = UPDATE;
                end else begin
                    w_next_state = FILL_ACC;
                end
            end
            UPDATE: begin
                w_upd_en     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed scoreboard bench for dcache_controller with a byte-wide memory model
// that stalls for the first cycle of every access.
module tb_dcache_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       read, write;
    logic [7:0] address, writedata, readdata;
    logic       busywait;
    logic       mem_read, mem_write;
    logic [7:0] mem_address, mem_writedata, mem_readdata;
    logic       mem_busywait;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } mem_op_t;

    mem_op_t    exp_mem[$];
    logic [7:0] exp_rd[$];
    logic [7:0] mem [256];
    int         acc_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    dcache_controller dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h05) ? 8'hAB : (a ^ 8'h5A);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: busy on the first cycle of each access, ready on the second.
    always @(posedge clock) begin
        if (mem_read || mem_write) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign mem_busywait = (mem_read || mem_write) && (acc_cnt == 0);
    assign mem_readdata = mem[mem_address];

    // Each accepted memory access is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (reset && (mem_read || mem_write) && !mem_busywait) begin
            if (exp_mem.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL mem_unexpected: observed wr=%0b addr=%0h, no access expected", mem_write, mem_address);
            end else begin
                mem_op_t e;
                e = exp_mem.pop_front();
                check("mem_op", {31'd0, mem_write}, {31'd0, e.wr});
                check("mem_addr", {24'd0, mem_address}, {24'd0, e.addr});
                if (e.wr) check("mem_wdata", {24'd0, mem_writedata}, {24'd0, e.data});
            end
            if (mem_write) mem[mem_address] = mem_writedata;
        end
    end

    task automatic push_fill(input logic [7:0] base);
        for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b0, base + 8'(i), 8'd0});
    endtask

    task automatic push_wb(input logic [7:0] base, input logic [31:0] bytes);
        for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b1, base + 8'(i), bytes[8*i +: 8]});
    endtask

    // One CPU access: counts cycles with busywait high, checks hit data, then releases.
    task automatic cpu_access(input string tag, input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wd, input logic [7:0] exp_data, input int exp_busy);
        int n;
        logic [7:0] e;
        @(negedge clock);
        read = rd; write = wr; address = addr; writedata = wd;
        if (rd) exp_rd.push_back(exp_data);
        #1;
        n = 0;
        while (busywait && n < 100) begin
            n++;
            @(negedge clock);
            #1;
        end
        check({tag, "_busy_cycles"}, n, exp_busy);
        if (rd) begin
            e = exp_rd.pop_front();
            check({tag, "_readdata"}, {24'd0, readdata}, {24'd0, e});
        end
        @(posedge clock);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        reset = 1'b0; read = 1'b0; write = 1'b0; address = 8'd0; writedata = 8'd0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_busywait", {31'd0, busywait}, 32'd0);
        check("rst_readdata", {24'd0, readdata}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_address", {24'd0, mem_address}, 32'd0);
        check("rst_mem_writedata", {24'd0, mem_writedata}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Clean read miss fills 0x04..0x07.
        push_fill(8'h04);
        cpu_access("read_miss_05", 1'b1, 1'b0, 8'h05, 8'd0, 8'hAB, 14);
        cpu_access("read_hit_06", 1'b1, 1'b0, 8'h06, 8'd0, init_val(8'h06), 0);
        cpu_access("write_hit_05", 1'b0, 1'b1, 8'h05, 8'h3C, 8'd0, 0);
        cpu_access("read_hit_05", 1'b1, 1'b0, 8'h05, 8'd0, 8'h3C, 0);

        // Dirty eviction of line 1 by tag 1.
        push_wb(8'h04, {init_val(8'h07), init_val(8'h06), 8'h3C, init_val(8'h04)});
        push_fill(8'h24);
        cpu_access("read_evict_25", 1'b1, 1'b0, 8'h25, 8'd0, init_val(8'h25), 26);
        check("mem05_after_wb", {24'd0, mem[8'h05]}, 32'h3C);

        // Write miss on a clean line: allocate, then write as a hit.
        push_fill(8'h48);
        cpu_access("write_miss_48", 1'b0, 1'b1, 8'h48, 8'h77, 8'd0, 14);
        cpu_access("read_hit_48", 1'b1, 1'b0, 8'h48, 8'd0, 8'h77, 0);
        check("mem48_unchanged", {24'd0, mem[8'h48]}, {24'd0, init_val(8'h48)});

        // Read and write together are ignored even on a miss.
        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 8'h70;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (busywait) n++;
            @(negedge clock);
        end
        check("rw_both_busy", n, 32'd0);
        read = 1'b0; write = 1'b0;
        cpu_access("read_hit_49", 1'b1, 1'b0, 8'h49, 8'd0, init_val(8'h49), 0);

        // Reset during the second fill access of a miss on 0x65.
        exp_mem.push_back('{1'b0, 8'h64, 8'd0});
        @(negedge clock);
        read = 1'b1; address = 8'h65;
        n = 0;
        while (exp_mem.size() != 0 && n < 50) begin @(negedge clock); #1; n++; end
        while (mem_read && n < 60) begin @(negedge clock); #1; n++; end
        while (!mem_read && n < 70) begin @(negedge clock); #1; n++; end
        check("reach_fill2_queue", exp_mem.size(), 32'd0);
        check("reach_fill2_mem_read", {31'd0, mem_read}, 32'd1);
        check("reach_fill2_addr", {24'd0, mem_address}, 32'h65);
        reset = 1'b0;
        #1;
        check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
        check("midrst_busywait", {31'd0, busywait}, 32'd0);
        check("midrst_mem_address", {24'd0, mem_address}, 32'd0);
        read = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        push_fill(8'h64);
        cpu_access("reread_65", 1'b1, 1'b0, 8'h65, 8'd0, init_val(8'h65), 14);

        repeat (3) @(negedge clock);
        check("exp_mem_drained", exp_mem.size(), 32'd0);
        check("exp_rd_drained", exp_rd.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
